// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding byte/half/word access to a word-addressed
// data memory, with sign/zero extension, read-modify-write sub-word stores and fault reporting.
module load_store_unit #(
  parameter int BITSIZE = 32,
  parameter int AW      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               ready,
  output logic               done,
  output logic [BITSIZE-1:0] rdata,
  output logic               fault,
  output logic [AW-1:0]      mem_addr,
  output logic [BITSIZE-1:0] mem_wdata,
  output logic               mem_write,
  output logic               mem_read,
  input  logic [BITSIZE-1:0] mem_rdata
);

  // One-hot so every handshake output is a single state flop.
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RD   = 4'b0010,
    WR   = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t state, state_n;

  logic               we_q;
  logic [2:0]         f3_q;
  logic [AW+1:0]      addr_q;
  logic [BITSIZE-1:0] wdata_q;
  logic [BITSIZE-1:0] rmw_q;
  logic               fault_q;

  logic               accept;
  logic               illegal;
  logic               misaligned;
  logic               req_fault;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [BITSIZE-1:0] load_val;
  logic [BITSIZE-1:0] merged;

  // Upper address bits alias onto the 64-word space and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign accept = (state == IDLE) && req;

  // Request legality is judged on the live inputs so a fault skips memory entirely.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr[0];
      3'b010:         misaligned = |addr[1:0];
      default:        illegal    = 1'b1;
    endcase
    if (we && funct3[2]) illegal = 1'b1;
  end

  assign req_fault = illegal | misaligned;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_fault)                  state_n = DONE;
          else if (!we)                   state_n = RD;
          else if (funct3[1:0] == 2'b10)  state_n = WR;
          else                            state_n = RD;
        end
      end
      RD:      state_n = we_q ? WR : DONE;
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: handshake strobes are direct one-hot flop bits.
  always_comb begin
    ready     = state[0];
    mem_read  = state[1];
    mem_write = state[2];
    done      = state[3];
    fault     = fault_q;
    mem_addr  = addr_q[AW+1:2];
    mem_wdata = '0;
    if (state == WR) mem_wdata = f3_q[1] ? wdata_q : merged;
  end

  // Lane selection and extension for loads, taken straight from the memory read data.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_val = {{(BITSIZE-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{(BITSIZE-16){half_sel[15]}}, half_sel};
      3'b100:  load_val = {{(BITSIZE-8){1'b0}}, byte_sel};
      3'b101:  load_val = {{(BITSIZE-16){1'b0}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word store: overlay the new lane on the word fetched during RD.
  always_comb begin
    merged = rmw_q;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  // Request capture and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rmw_q   <= '0;
      rdata   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we;
        f3_q    <= funct3;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata[BITSIZE-1:0];
        fault_q <= req_fault;
      end
      if (state == RD) begin
        if (we_q) rmw_q <= mem_rdata;
        else      rdata <= load_val;
      end
      if (state == DONE) fault_q <= 1'b0;
    end
  end

endmodule
